// File: rtl/mac_stream_source.sv
// Load-stream responder: reads trans_size words from TCDM starting at base and streams them out in order.
// Optional macro MAC_STREAM_SOURCE_STRIDE_EN adds a stride_i port (default stride is one data word).
module mac_stream_source #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    req_start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [LEN_WIDTH-1:0]    trans_size_i,
`ifdef MAC_STREAM_SOURCE_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0]   stride_i,
`endif
    output logic                    ready_start_o,
    output logic                    done_o,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    input  logic                    tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
    output logic                    stream_valid_o,
    input  logic                    stream_ready_i,
    output logic [DATA_WIDTH-1:0]   stream_data_o
);
    localparam int CNT_W = LEN_WIDTH + 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   base, stride;
    logic [CNT_W-1:0]        size, issued, popped, inflight, discard, count;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];
    logic                    zero_done;
    logic                    start, grant, push, drop, pop, last_pop;

    assign ready_start_o  = (state == IDLE) && (discard == '0);
    assign start          = ready_start_o && req_start_i;
    assign tcdm_req_o     = (state == REQ) && (issued < size)
                            && ((inflight + count) < CNT_W'(BUF_DEPTH));
    assign grant          = tcdm_req_o && tcdm_gnt_i;
    assign tcdm_add_o     = tcdm_req_o ? base + ADDR_WIDTH'(issued) * stride : '0;
    assign tcdm_wen_o     = 1'b1;
    assign tcdm_be_o      = '1;

    // Responses owed to a cleared job are swallowed by the discard counter.
    assign push           = tcdm_r_valid_i && (discard == '0) && !clear_i;
    assign drop           = tcdm_r_valid_i && (discard != '0);
    assign stream_valid_o = (count != '0);
    assign stream_data_o  = stream_valid_o ? mem[rd_ptr] : '0;
    assign pop            = stream_valid_o && stream_ready_i && !clear_i;
    assign last_pop       = (state == DRAIN) && pop && ((popped + CNT_W'(1)) == size);
    assign done_o         = zero_done || last_pop;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && (trans_size_i != '0)) state_next = REQ;
            REQ:     if (grant && ((issued + CNT_W'(1)) == size)) state_next = DRAIN;
            DRAIN:   if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear_i) state_next = IDLE;
    end

`ifdef MAC_STREAM_SOURCE_STRIDE_EN
    always_ff @(posedge clk_i) begin
        if (start) stride <= stride_i;
    end
`else
    assign stride = ADDR_WIDTH'(DATA_WIDTH / 8);
`endif

    always_ff @(posedge clk_i) begin
        if (start) begin
            base <= base_addr_i;
            size <= CNT_W'(trans_size_i);
        end
        if (push) mem[wr_ptr] <= tcdm_r_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            issued    <= '0;
            popped    <= '0;
            inflight  <= '0;
            discard   <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            zero_done <= 1'b0;
        end else if (clear_i) begin
            state     <= IDLE;
            issued    <= '0;
            popped    <= '0;
            inflight  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            zero_done <= 1'b0;
            // A grant in this cycle still produces a response, so it joins the discard debt.
            discard   <= discard + inflight + CNT_W'(grant) - CNT_W'(tcdm_r_valid_i);
        end else begin
            state     <= state_next;
            zero_done <= start && (trans_size_i == '0);
            issued    <= start ? '0 : issued + CNT_W'(grant);
            popped    <= start ? '0 : popped + CNT_W'(pop);
            inflight  <= inflight + CNT_W'(grant) - CNT_W'(push);
            discard   <= discard - CNT_W'(drop);
            count     <= count + CNT_W'(push) - CNT_W'(pop);
            wr_ptr    <= wr_ptr + PTR_W'(push);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            if (push && !pop) assert (count < CNT_W'(BUF_DEPTH));
        end
    end
endmodule

// File: tb/tb_mac_stream_source.sv
// Directed bench for mac_stream_source: TCDM responder model with programmable latency and grant stalls.
module tb_mac_stream_source;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        req_start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] trans_size = '0;
    logic        ready_start, done, tcdm_req, tcdm_wen;
    logic        tcdm_gnt = 1'b1;
    logic [31:0] tcdm_add;
    logic [3:0]  tcdm_be;
    logic        r_valid = 1'b0;
    logic [31:0] r_data = '0;
    logic        stream_valid, stream_ready = 1'b1;
    logic [31:0] stream_data;

    mac_stream_source #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .BUF_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_start_i(req_start),
        .base_addr_i(base_addr), .trans_size_i(trans_size), .ready_start_o(ready_start),
        .done_o(done), .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
        .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be), .tcdm_r_valid_i(r_valid),
        .tcdm_r_data_i(r_data), .stream_valid_o(stream_valid), .stream_ready_i(stream_ready),
        .stream_data_o(stream_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    int          cyc = 0;
    int          lat = 1;
    int          stall_idx = -1;
    int          stall_left = 0;
    int          done_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] grant_log[$];
    logic [31:0] stall_log[$];
    logic [31:0] rx_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and stream monitor run on the falling edge.
    always @(negedge clk) begin
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            r_valid = 1'b1;
            r_data  = fdata(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            resp_cnt++;
        end else begin
            r_valid = 1'b0;
            r_data  = '0;
        end
        if (tcdm_req) begin
            if (grant_log.size() == stall_idx && stall_left > 0) begin
                tcdm_gnt = 1'b0;
                stall_left--;
                stall_log.push_back(tcdm_add);
            end else begin
                tcdm_gnt = 1'b1;
                grant_log.push_back(tcdm_add);
                pend_addr.push_back(tcdm_add);
                pend_due.push_back(cyc + lat);
            end
        end else begin
            tcdm_gnt = 1'b1;
        end
        if (stream_valid && stream_ready) rx_log.push_back(stream_data);
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        stall_log.delete();
        rx_log.delete();
        done_cnt = 0;
    endtask

    task automatic start_job(input logic [31:0] b, input logic [15:0] s);
        @(posedge clk); #1;
        req_start = 1'b1; base_addr = b; trans_size = s;
        @(posedge clk); #1;
        req_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int exp_rx);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done_cnt != 0, 1);
        check({tag, "_rx_at_done"}, rx_log.size(), exp_rx);
        tick();
        check({tag, "_ready_after"}, ready_start, 1);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] b, input int n);
        check({tag, "_rx_count"}, rx_log.size(), n);
        check({tag, "_grant_count"}, grant_log.size(), n);
        for (int i = 0; i < n && i < rx_log.size() && i < grant_log.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), grant_log[i], b + 32'(i) * 32'd4);
            check($sformatf("%s_data%0d", tag, i), rx_log[i], fdata(b + 32'(i) * 32'd4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int resp0;
        logic leaked;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready_start, 1);
        check("rst_done", done, 0);
        check("rst_req", tcdm_req, 0);
        check("rst_valid", stream_valid, 0);
        check("rst_add", tcdm_add, 0);
        check("rst_data", stream_data, 0);
        check("rst_wen", tcdm_wen, 1);
        check("rst_be", tcdm_be, 4'hF);
        rst_n = 1'b1;

        // Basic job
        clear_logs();
        start_job(32'h1000, 16'd4);
        wait_done("basic", 50, 4);
        check_stream("basic", 32'h1000, 4);
        check("basic_done_cnt", done_cnt, 1);

        // Backpressure
        clear_logs();
        @(posedge clk); #1;
        stream_ready = 1'b0;
        start_job(32'h1000, 16'd8);
        repeat (20) tick();
        check("bp_grants_held", grant_log.size(), 4);
        check("bp_req_low", tcdm_req, 0);
        check("bp_valid", stream_valid, 1);
        check("bp_no_rx", rx_log.size(), 0);
        @(posedge clk); #1;
        stream_ready = 1'b1;
        wait_done("bp", 100, 8);
        check_stream("bp", 32'h1000, 8);
        tick();
        check("bp_done_cnt", done_cnt, 1);

        // Zero length
        clear_logs();
        start_job(32'h5000, 16'd0);
        tick();
        check("zero_done_pulse", done, 1);
        check("zero_ready", ready_start, 1);
        check("zero_req", tcdm_req, 0);
        tick();
        check("zero_done_low", done, 0);
        check("zero_ready2", ready_start, 1);
        check("zero_no_grants", grant_log.size(), 0);
        check("zero_no_stalls", stall_log.size(), 0);

        // Grant stall on the second request
        clear_logs();
        stall_idx = 1; stall_left = 3;
        start_job(32'h1000, 16'd4);
        wait_done("stall", 60, 4);
        check_stream("stall", 32'h1000, 4);
        check("stall_cycles", stall_log.size(), 3);
        for (int i = 0; i < stall_log.size(); i++)
            check($sformatf("stall_addr%0d", i), stall_log[i], 32'h1004);
        stall_idx = -1; stall_left = 0;

        // Clear with two reads in flight
        clear_logs();
        lat = 6; stall_idx = 2; stall_left = 1000;
        resp0 = resp_cnt;
        start_job(32'h1000, 16'd4);
        n = 0;
        while (grant_log.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check("clr_two_grants", grant_log.size(), 2);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        stall_idx = -1; stall_left = 0;
        tick();
        check("clr_ready_low", ready_start, 0);
        check("clr_req_low", tcdm_req, 0);
        check("clr_valid_low", stream_valid, 0);
        check("clr_pending_resp", resp_cnt - resp0, 0);
        leaked = 1'b0;
        n = 0;
        while (!ready_start && n < 30) begin
            if (stream_valid) leaked = 1'b1;
            tick();
            n++;
        end
        check("clr_ready_back", ready_start, 1);
        check("clr_resp_dropped", resp_cnt - resp0, 2);
        check("clr_no_leak", leaked, 0);
        check("clr_no_rx", rx_log.size(), 0);
        check("clr_no_done", done_cnt, 0);
        lat = 1;
        clear_logs();
        start_job(32'h2000, 16'd1);
        wait_done("post_clr", 30, 1);
        check_stream("post_clr", 32'h2000, 1);

        // Address wrap with an ignored start during REQ
        clear_logs();
        stall_idx = 0; stall_left = 3;
        start_job(32'hFFFF_FFFC, 16'd2);
        check("wrap_in_req_ready", ready_start, 0);
        @(posedge clk); #1;
        req_start = 1'b1; base_addr = 32'h3000; trans_size = 16'd5;
        @(posedge clk); #1;
        req_start = 1'b0;
        wait_done("wrap", 40, 2);
        repeat (5) tick();
        check("wrap_grants", grant_log.size(), 2);
        if (grant_log.size() == 2 && rx_log.size() == 2) begin
            check("wrap_addr0", grant_log[0], 32'hFFFF_FFFC);
            check("wrap_addr1", grant_log[1], 32'h0000_0000);
            check("wrap_data0", rx_log[0], fdata(32'hFFFF_FFFC));
            check("wrap_data1", rx_log[1], fdata(32'h0000_0000));
        end else begin
            check("wrap_rx_count", rx_log.size(), 2);
        end
        check("wrap_stall_addr", stall_log.size() > 0 ? stall_log[0] : 32'h0, 32'hFFFF_FFFC);
        check("wrap_done_cnt", done_cnt, 1);
        check("wrap_req_idle", tcdm_req, 0);
        stall_idx = -1; stall_left = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_stream_source.md
Name: mac_stream_source

Overview:
- Load-stream responder for the MAC accelerator's controller start handshake. Accepts a one-cycle `req_start_i` with base address and length, and advertises `ready_start_o` whenever it can take a new job.
- Issues TCDM word reads (req/gnt, in-order `r_valid`) and buffers the responses. Streams them out on a valid/ready interface toward the engine.
- One instance per input operand (a, b, c).

Parameters:
- DATA_WIDTH, 32, TCDM word and stream data width (multiple of 8).
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 16, width of the transfer length in words.
- BUF_DEPTH, 4, response buffer entries; also the credit limit on in-flight reads (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear
- req_start_i  in  1  job start request, sampled only when ready_start_o=1
- base_addr_i  in  ADDR_WIDTH  first byte address, latched on accepted start
- trans_size_i  in  LEN_WIDTH  number of words, latched on accepted start
- ready_start_o  out  1  block can accept a start
- done_o  out  1  one-cycle pulse when the last word of a job leaves on the stream
- tcdm_req_o  out  1  read request
- tcdm_gnt_i  in  1  request grant
- tcdm_add_o  out  ADDR_WIDTH  request byte address
- tcdm_wen_o  out  1  constant 1 (read)
- tcdm_be_o  out  DATA_WIDTH/8  constant all-ones
- tcdm_r_valid_i  in  1  response valid, in request order, ≥1 cycle after grant
- tcdm_r_data_i  in  DATA_WIDTH  response data
- stream_valid_o  out  1  output data valid
- stream_ready_i  in  1  consumer ready
- stream_data_o  out  DATA_WIDTH  output data

Behaviour:
- Reset (rst_ni=0): state IDLE, all counters and buffer empty. ready_start_o=1; done_o=0, tcdm_req_o=0, stream_valid_o=0, tcdm_add_o=0, stream_data_o=0.
- States: IDLE, REQ, DRAIN.
- IDLE:
  - ready_start_o=1 iff the discard counter is 0.
  - On req_start_i & ready_start_o, latch base_addr_i and trans_size_i.
  - If trans_size_i=0: pulse done_o next cycle, stay IDLE, issue no requests.
  - Otherwise go to REQ.
- REQ:
  - tcdm_req_o=1 while issued<size and (inflight+buffered)<BUF_DEPTH.
  - tcdm_add_o = base + issued*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH (wraps silently).
  - Request held stable until tcdm_gnt_i; grant increments issued and inflight.
  - When the last request is granted, go to DRAIN.
- DRAIN:
  - Wait until all size words have been popped on the stream.
  - On the cycle the final word is accepted (stream_valid_o & stream_ready_i): pulse done_o, go to IDLE.
  - ready_start_o is 1 in the following cycle.
- Buffer:
  - tcdm_r_valid_i pushes tcdm_r_data_i and decrements inflight.
  - stream_valid_o = buffer not empty; stream_data_o = head entry (registered output, no combinational path from tcdm_r_data_i).
  - Push and pop in the same cycle are legal, including when the buffer is full.
  - The credit rule guarantees no overflow; overflow is an assertion error.
- ready_start_o=0 in REQ and DRAIN; req_start_i there is ignored.
- Words popped in REQ count toward completion. A job never pulses done_o before all size words are popped.
- clear_i:
  - Next cycle: state IDLE, buffer flushed, issued/popped counters 0, tcdm_req_o and stream_valid_o dropped.
  - Outstanding inflight count moves to the discard counter. Later responses decrement it and are dropped.
  - ready_start_o stays 0 until the discard counter reaches 0.
  - clear_i has priority over start, grant and response in the same cycle.
  - done_o is not pulsed on clear.
- Asynchronous reset mid-operation: immediate return to reset values; in-flight responses are not tracked.
- Width rules: counters are LEN_WIDTH+1 bits; the offset multiply is truncated to ADDR_WIDTH.

Optional Feature:
- Macro MAC_STREAM_SOURCE_STRIDE_EN.
- Defined: adds input stride_i (ADDR_WIDTH), latched with base on accepted start. Address = base + issued*stride (modulo 2^ADDR_WIDTH); stride 0 rereads the same word.
- Undefined: no stride_i port; stride fixed to DATA_WIDTH/8.

Test Plan:
- Basic job: base=0x1000, size=4, gnt always 1, r_valid 1 cycle after grant, ready=1.
  - Response: addresses 0x1000/0x1004/0x1008/0x100C.
  - Data stream out in order; done_o pulses once with the 4th pop; ready_start_o returns to 1 the next cycle.
- Backpressure: size=8, stream_ready_i=0 for 20 cycles.
  - Response: exactly BUF_DEPTH=4 requests granted, then tcdm_req_o=0.
  - After release, all 8 words arrive in order; done_o pulses once.
- Zero length: size=0 → done_o pulse the cycle after start, no tcdm_req_o, ready_start_o stays 1.
- Grant stalls: gnt low for 3 cycles on the 2nd request → tcdm_add_o stable at 0x1004 during the stall, no duplicate requests.
- Clear mid-job with 2 reads in flight:
  - ready_start_o stays 0 until both late responses are dropped; they never appear on the stream.
  - A new job (base=0x2000, size=1) then completes correctly.
- Wrap and ignored start: base=0xFFFFFFFC, size=2 → addresses 0xFFFFFFFC then 0x00000000; a req_start_i pulse during REQ is ignored.
